io_register_file: RTL and testbench
===================================

Name:
io_register_file

Overview:
- Parametrised general-purpose register file for the CPU datapath.
- Two asynchronous read ports and one synchronous write port.
- Low addresses hold memory-mapped input registers: zero, synchronised switches, a ready status with a sticky rise flag, and a pattern-match event counter.
- The top NUM_OUT addresses are output registers, each with a one-cycle update strobe.
- Sits between the decoder/ALU and board I/O.

Parameters:
- BUS_WIDTH, 8, data width of every register and port word.
- ADDR_WIDTH, 3, register address width; N = 2**ADDR_WIDTH; must be >= 3.
- NUM_OUT, 1, number of output registers, legal range 1..N-4, mapped at addresses N-NUM_OUT..N-1.
- SYNC_STAGES, 2, flop depth of the input synchronisers; must be >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sw  input  BUS_WIDTH  asynchronous switch inputs.
- ready_in  input  1  asynchronous ready level.
- pattern_match  input  1  asynchronous match level.
- we  input  1  write enable.
- wr_addr  input  ADDR_WIDTH  write address.
- wr_data  input  BUS_WIDTH  write data.
- rd_addr_a  input  ADDR_WIDTH  read address, port A.
- rd_addr_b  input  ADDR_WIDTH  read address, port B.
- rd_en_a  input  1  port A read-commit strobe; drives clear-on-read.
- rd_data_a  output  BUS_WIDTH  read data, port A (combinational).
- rd_data_b  output  BUS_WIDTH  read data, port B (combinational).
- out_port  output  NUM_OUT*BUS_WIDTH  slice k = register N-NUM_OUT+k.
- out_stb  output  NUM_OUT  registered update strobe per output register.

Behaviour:
- Reset, async on rst_n low: all storage registers, synchroniser flops, the ready edge-detect flop, the sticky flag, the match counter and out_stb clear to 0. out_port reads 0 until the first write.
- Address map:
  - 0 reads 0.
  - 1 reads sw_sync.
  - 2 reads {zeros, ready_sticky, ready_sync}, i.e. bit1 = sticky, bit0 = level.
  - 3 reads match_cnt.
  - 4..N-1 read their storage registers.
- Both read ports decode independently and combinationally; same-address reads on A and B are legal.
- Synchronisers: sw, ready_in and pattern_match each pass through SYNC_STAGES flops. An input change is visible on a read port SYNC_STAGES rising edges later.
- ready_sticky:
  - Set on the edge after a synchronised rising edge of ready (ready_sync high, previous value low).
  - Cleared on an edge where rd_en_a=1 and rd_addr_a=2.
  - If set and clear coincide, set wins.
  - Port B reads never clear it.
- match_cnt:
  - Increments by 1 per synchronised rising edge of pattern_match.
  - Saturates at all-ones; no wrap.
  - Any write to address 3 clears it. If the write coincides with an edge, the result is 1.
- Writes:
  - Take effect on the rising edge with we=1.
  - Writes to addresses 0, 1 and 2 are ignored.
  - A write to address 3 only clears the counter; wr_data is discarded.
  - Writes to 4..N-1 update storage.
  - A read of wr_addr in the same cycle returns the old value (see Optional Feature).
- out_stb[k] is high for exactly the cycle after an edge that wrote output register k. It coincides with the new out_port value. Back-to-back writes hold it high on consecutive cycles, and writing the same value still pulses.
- Reset mid-operation: all state clears immediately, and pending strobes and counts are lost.
- Illegal parameter values (range violations above) must stop elaboration.

Optional Feature:
- Macro: IO_REGFILE_WRITE_FORWARD_EN.
- Defined: when we=1 and rd_addr_x = wr_addr with wr_addr >= 4, rd_data_x returns wr_data combinationally in that same cycle. Addresses 0..3 are never forwarded.
- Undefined: same-cycle reads return the pre-write value.

Test Plan:
- Reset, then write 0x5A to addr 4 and 0xC3 to addr 7 (NUM_OUT=1) -> rd addr 4 = 0x5A; out_port = 0xC3; out_stb high exactly one cycle after the addr 7 write.
- Write 0xFF to addr 0, 1 and 2 -> reads of addr 0 = 0x00, addr 1 = sw_sync, addr 2 unchanged; no storage modified.
- sw = 0xA5 applied -> rd addr 1 shows the old value for 1 cycle and 0xA5 from the SYNC_STAGES-th edge onward.
- Pulse ready_in high, hold, then drop -> addr 2 = 0x03, then 0x02 after the drop. Issue rd_en_a with rd_addr_a=2 -> 0x00. Coincident new rise and clear -> bit1 stays 1.
- Apply 300 pattern_match pulses (BUS_WIDTH=8) -> counter reads 0xFF. Write addr 3 -> 0x00. Write coinciding with an edge -> 0x01.
- Write addr 5 while reading addr 5 on both ports -> old value without IO_REGFILE_WRITE_FORWARD_EN, wr_data with it. Assert rst_n low mid-sequence -> all reads of 4..N-1, out_port, out_stb and the counter are 0.

Source files
------------

// File: rtl/io_register_file.sv
// Register file with two async read ports, one sync write port, memory-mapped
// inputs at 0..3 and output registers at the top. Optional: IO_REGFILE_WRITE_FORWARD_EN.
module io_register_file #(
  parameter int unsigned BUS_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH  = 3,
  parameter int unsigned NUM_OUT     = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [BUS_WIDTH-1:0]         sw,
  input  logic                         ready_in,
  input  logic                         pattern_match,
  input  logic                         we,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [BUS_WIDTH-1:0]         wr_data,
  input  logic [ADDR_WIDTH-1:0]        rd_addr_a,
  input  logic [ADDR_WIDTH-1:0]        rd_addr_b,
  input  logic                         rd_en_a,
  output logic [BUS_WIDTH-1:0]         rd_data_a,
  output logic [BUS_WIDTH-1:0]         rd_data_b,
  output logic [NUM_OUT*BUS_WIDTH-1:0] out_port,
  output logic [NUM_OUT-1:0]           out_stb
);

  localparam int unsigned N        = 1 << ADDR_WIDTH;
  localparam int unsigned OUT_BASE = N - NUM_OUT;

  generate
    if (ADDR_WIDTH < 3) begin : g_bad_addr_width
      $error("io_register_file: ADDR_WIDTH must be >= 3");
    end
    if (NUM_OUT < 1 || NUM_OUT > N - 4) begin : g_bad_num_out
      $error("io_register_file: NUM_OUT must be in 1..N-4");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
      $error("io_register_file: SYNC_STAGES must be >= 2");
    end
    if (BUS_WIDTH < 2) begin : g_bad_bus_width
      $error("io_register_file: BUS_WIDTH must be >= 2");
    end
  endgenerate

  logic [SYNC_STAGES-1:0][BUS_WIDTH-1:0] sw_sync_q;
  logic [SYNC_STAGES-1:0]                ready_sync_q;
  logic [SYNC_STAGES-1:0]                match_sync_q;
  logic                                  ready_prev_q;
  logic                                  match_prev_q;
  logic                                  ready_sticky_q, ready_sticky_d;
  logic [BUS_WIDTH-1:0]                  match_cnt_q, match_cnt_d;
  logic [BUS_WIDTH-1:0]                  mem_q [N-1:4];
  logic [NUM_OUT-1:0]                    out_stb_q;
  logic [BUS_WIDTH-1:0]                  rd_vec [N];

  logic ready_sync, match_sync, ready_rise, match_rise, sticky_clr, cnt_clr;

  assign ready_sync = ready_sync_q[SYNC_STAGES-1];
  assign match_sync = match_sync_q[SYNC_STAGES-1];
  assign ready_rise = ready_sync & ~ready_prev_q;
  assign match_rise = match_sync & ~match_prev_q;
  assign sticky_clr = rd_en_a && (rd_addr_a == ADDR_WIDTH'(2));
  assign cnt_clr    = we && (wr_addr == ADDR_WIDTH'(3));

  // Synchronisers and edge-detect history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_sync_q    <= '0;
      ready_sync_q <= '0;
      match_sync_q <= '0;
      ready_prev_q <= 1'b0;
      match_prev_q <= 1'b0;
    end else begin
      sw_sync_q    <= {sw_sync_q[SYNC_STAGES-2:0], sw};
      ready_sync_q <= {ready_sync_q[SYNC_STAGES-2:0], ready_in};
      match_sync_q <= {match_sync_q[SYNC_STAGES-2:0], pattern_match};
      ready_prev_q <= ready_sync;
      match_prev_q <= match_sync;
    end
  end

  // Sticky ready flag (set beats clear) and saturating match counter
  always_comb begin
    ready_sticky_d = ready_sticky_q;
    match_cnt_d    = match_cnt_q;
    if (sticky_clr) ready_sticky_d = 1'b0;
    if (ready_rise) ready_sticky_d = 1'b1;
    if (cnt_clr) begin
      match_cnt_d = BUS_WIDTH'(match_rise);
    end else if (match_rise && (match_cnt_q != '1)) begin
      match_cnt_d = match_cnt_q + BUS_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_sticky_q <= 1'b0;
      match_cnt_q    <= '0;
    end else begin
      ready_sticky_q <= ready_sticky_d;
      match_cnt_q    <= match_cnt_d;
    end
  end

  // Storage registers and per-output update strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 4; i < N; i++) mem_q[i] <= '0;
      out_stb_q <= '0;
    end else begin
      for (int unsigned i = 4; i < N; i++) begin
        if (we && (wr_addr == ADDR_WIDTH'(i))) mem_q[i] <= wr_data;
      end
      for (int unsigned k = 0; k < NUM_OUT; k++) begin
        out_stb_q[k] <= we && (wr_addr == ADDR_WIDTH'(OUT_BASE + k));
      end
    end
  end

  always_comb begin
    rd_vec[0]      = '0;
    rd_vec[1]      = sw_sync_q[SYNC_STAGES-1];
    rd_vec[2]      = '0;
    rd_vec[2][1:0] = {ready_sticky_q, ready_sync};
    rd_vec[3]      = match_cnt_q;
    for (int unsigned i = 4; i < N; i++) rd_vec[i] = mem_q[i];
  end

`ifdef IO_REGFILE_WRITE_FORWARD_EN
  logic fwd_ok;
  assign fwd_ok    = we && (wr_addr >= ADDR_WIDTH'(4));
  assign rd_data_a = (fwd_ok && (rd_addr_a == wr_addr)) ? wr_data : rd_vec[rd_addr_a];
  assign rd_data_b = (fwd_ok && (rd_addr_b == wr_addr)) ? wr_data : rd_vec[rd_addr_b];
`else
  assign rd_data_a = rd_vec[rd_addr_a];
  assign rd_data_b = rd_vec[rd_addr_b];
`endif

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
    assign out_port[k*BUS_WIDTH +: BUS_WIDTH] = mem_q[OUT_BASE + k];
  end

  assign out_stb = out_stb_q;

endmodule

// File: tb/tb_io_register_file.sv
// Directed self-checking bench for io_register_file (default parameters).
module tb_io_register_file;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] sw;
  logic       ready_in, pattern_match;
  logic       we;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [2:0] rd_addr_a, rd_addr_b;
  logic       rd_en_a;
  logic [7:0] rd_data_a, rd_data_b;
  logic [7:0] out_port;
  logic [0:0] out_stb;

  int tests = 0;
  int fails = 0;

  io_register_file dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .ready_in(ready_in),
    .pattern_match(pattern_match), .we(we), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_en_a(rd_en_a), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .out_port(out_port), .out_stb(out_stb)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    we = 1'b1; wr_addr = a; wr_data = d;
    tick();
    we = 1'b0;
  endtask

  task automatic rd_a(input logic [2:0] a, output logic [7:0] d);
    rd_addr_a = a;
    #1;
    d = rd_data_a;
  endtask

  task automatic rd_b(input logic [2:0] a, output logic [7:0] d);
    rd_addr_b = a;
    #1;
    d = rd_data_b;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst_n = 1'b0;
    #2;
    for (int i = 0; i < 8; i++) begin
      rd_a(3'(i), d);
      tests++;
      if (d !== 8'h00) begin
        fails++; $display("FAIL reset_addr%0d: got %h want 00", i, d);
      end
    end
    tests++;
    if (out_port !== 8'h00 || out_stb !== 1'b0) begin
      fails++; $display("FAIL reset_out: out_port %h out_stb %b want 00/0", out_port, out_stb);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_out();
    logic [7:0] d;
    wr(3'd4, 8'h5A);
    tests++;
    if (out_stb !== 1'b0) begin
      fails++; $display("FAIL stb_non_out: got %b want 0", out_stb);
    end
    rd_a(3'd4, d);
    tests++;
    if (d !== 8'h5A) begin fails++; $display("FAIL wr_addr4_a: got %h want 5a", d); end
    rd_b(3'd4, d);
    tests++;
    if (d !== 8'h5A) begin fails++; $display("FAIL wr_addr4_b: got %h want 5a", d); end
    tick();
    wr(3'd7, 8'hC3);
    tests++;
    if (out_stb !== 1'b1 || out_port !== 8'hC3) begin
      fails++; $display("FAIL out_write: stb %b port %h want 1/c3", out_stb, out_port);
    end
    tick();
    tests++;
    if (out_stb !== 1'b0 || out_port !== 8'hC3) begin
      fails++; $display("FAIL out_stb_drop: stb %b port %h want 0/c3", out_stb, out_port);
    end
  endtask

  task automatic test_ignored_writes();
    logic [7:0] d;
    logic [7:0] exp [8];
    exp = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h5A, 8'h00, 8'h00, 8'hC3};
    wr(3'd0, 8'hFF);
    wr(3'd1, 8'hFF);
    wr(3'd2, 8'hFF);
    tests++;
    if (out_stb !== 1'b0) begin fails++; $display("FAIL ign_stb: got %b want 0", out_stb); end
    for (int i = 0; i < 8; i++) begin
      if (i == 3) continue;
      rd_a(3'(i), d);
      tests++;
      if (d !== exp[i]) begin
        fails++; $display("FAIL ign_addr%0d: got %h want %h", i, d, exp[i]);
      end
    end
  endtask

  task automatic test_sync();
    logic [7:0] d;
    tick();
    sw = 8'hA5;
    tick();
    rd_a(3'd1, d);
    tests++;
    if (d !== 8'h00) begin fails++; $display("FAIL sync_edge1: got %h want 00", d); end
    tick();
    rd_a(3'd1, d);
    tests++;
    if (d !== 8'hA5) begin fails++; $display("FAIL sync_edge2: got %h want a5", d); end
  endtask

  task automatic test_ready();
    logic [7:0] d;
    tick();
    rd_addr_b = 3'd2;
    ready_in = 1'b1;
    tick(); tick();
    rd_a(3'd2, d);
    tests++;
    if (d !== 8'h01) begin fails++; $display("FAIL ready_level: got %h want 01", d); end
    tick();
    rd_a(3'd2, d);
    tests++;
    if (d !== 8'h03) begin fails++; $display("FAIL ready_sticky: got %h want 03", d); end
    tick(); tick();
    ready_in = 1'b0;
    tick(); tick();
    rd_a(3'd2, d);
    tests++;
    if (d !== 8'h02) begin fails++; $display("FAIL ready_drop: got %h want 02", d); end
    tests++;
    if (rd_data_b !== 8'h02) begin fails++; $display("FAIL ready_portb_noclr: got %h want 02", rd_data_b); end
    rd_en_a = 1'b1;
    tick();
    rd_en_a = 1'b0;
    rd_a(3'd2, d);
    tests++;
    if (d !== 8'h00) begin fails++; $display("FAIL ready_clear: got %h want 00", d); end
    ready_in = 1'b1;
    tick(); tick();
    rd_en_a = 1'b1;
    tick();
    rd_en_a = 1'b0;
    rd_a(3'd2, d);
    tests++;
    if (d !== 8'h03) begin fails++; $display("FAIL ready_set_wins: got %h want 03", d); end
    ready_in = 1'b0;
    rd_addr_b = 3'd0;
  endtask

  task automatic test_match();
    logic [7:0] d;
    tick();
    for (int i = 0; i < 5; i++) begin
      pattern_match = 1'b1; tick();
      pattern_match = 1'b0; tick();
    end
    tick(); tick(); tick(); tick();
    rd_a(3'd3, d);
    tests++;
    if (d !== 8'd5) begin fails++; $display("FAIL match_count5: got %h want 05", d); end
    for (int i = 0; i < 295; i++) begin
      pattern_match = 1'b1; tick();
      pattern_match = 1'b0; tick();
    end
    tick(); tick(); tick(); tick();
    rd_a(3'd3, d);
    tests++;
    if (d !== 8'hFF) begin fails++; $display("FAIL match_saturate: got %h want ff", d); end
    wr(3'd3, 8'h77);
    rd_a(3'd3, d);
    tests++;
    if (d !== 8'h00) begin fails++; $display("FAIL match_clear: got %h want 00", d); end
    tick();
    pattern_match = 1'b1;
    tick(); tick();
    wr(3'd3, 8'h55);
    rd_a(3'd3, d);
    tests++;
    if (d !== 8'h01) begin fails++; $display("FAIL match_clr_edge: got %h want 01", d); end
    pattern_match = 1'b0;
    tick(); tick(); tick();
    rd_a(3'd3, d);
    tests++;
    if (d !== 8'h01) begin fails++; $display("FAIL match_hold: got %h want 01", d); end
  endtask

  task automatic test_same_cycle();
    logic [7:0] exp_fwd;
`ifdef IO_REGFILE_WRITE_FORWARD_EN
    exp_fwd = 8'h99;
`else
    exp_fwd = 8'h11;
`endif
    wr(3'd5, 8'h11);
    tick();
    we = 1'b1; wr_addr = 3'd5; wr_data = 8'h99;
    rd_addr_a = 3'd5; rd_addr_b = 3'd5;
    #1;
    tests++;
    if (rd_data_a !== exp_fwd || rd_data_b !== exp_fwd) begin
      fails++; $display("FAIL same_cycle: a %h b %h want %h", rd_data_a, rd_data_b, exp_fwd);
    end
    tick();
    we = 1'b0;
    #1;
    tests++;
    if (rd_data_a !== 8'h99 || rd_data_b !== 8'h99) begin
      fails++; $display("FAIL after_write5: a %h b %h want 99", rd_data_a, rd_data_b);
    end
    we = 1'b1; wr_addr = 3'd3; wr_data = 8'hAA; rd_addr_a = 3'd3;
    #1;
    tests++;
    if (rd_data_a !== 8'h01) begin fails++; $display("FAIL no_fwd_addr3: got %h want 01", rd_data_a); end
    tick();
    we = 1'b0;
    #1;
    tests++;
    if (rd_data_a !== 8'h00) begin fails++; $display("FAIL addr3_cleared: got %h want 00", rd_data_a); end
  endtask

  task automatic test_back_to_back();
    tick();
    we = 1'b1; wr_addr = 3'd7; wr_data = 8'h10;
    tick();
    tests++;
    if (out_stb !== 1'b1 || out_port !== 8'h10) begin
      fails++; $display("FAIL b2b_first: stb %b port %h want 1/10", out_stb, out_port);
    end
    tick();
    we = 1'b0;
    tests++;
    if (out_stb !== 1'b1) begin fails++; $display("FAIL b2b_second: stb %b want 1", out_stb); end
    tick();
    tests++;
    if (out_stb !== 1'b0 || out_port !== 8'h10) begin
      fails++; $display("FAIL b2b_end: stb %b port %h want 0/10", out_stb, out_port);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    pattern_match = 1'b1; tick();
    pattern_match = 1'b0; tick(); tick(); tick();
    wr(3'd6, 8'h42);
    we = 1'b1; wr_addr = 3'd7; wr_data = 8'h3C;
    tick();
    we = 1'b0;
    tests++;
    if (out_stb !== 1'b1 || rd_data_a === 8'h00) begin
      fails++; $display("FAIL pre_reset: stb %b cnt %h want 1/nonzero", out_stb, rd_data_a);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (out_stb !== 1'b0 || out_port !== 8'h00) begin
      fails++; $display("FAIL mid_reset_out: stb %b port %h want 0/00", out_stb, out_port);
    end
    for (int i = 2; i < 8; i++) begin
      rd_a(3'(i), d);
      tests++;
      if (d !== 8'h00) begin fails++; $display("FAIL mid_reset_addr%0d: got %h want 00", i, d); end
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; sw = 8'h00; ready_in = 1'b0; pattern_match = 1'b0;
    we = 1'b0; wr_addr = 3'd0; wr_data = 8'h00;
    rd_addr_a = 3'd0; rd_addr_b = 3'd0; rd_en_a = 1'b0;
    test_reset();
    test_write_out();
    test_ignored_writes();
    test_sync();
    test_ready();
    test_match();
    test_same_cycle();
    test_back_to_back();
    rd_addr_a = 3'd3;
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
